// File: rtl/fifo_test_sequencer.sv
// rtl/fifo_test_sequencer.sv - tick-paced write/read/compare traffic generator for a board FIFO
module fifo_test_sequencer #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 16,
    parameter int WR_PERIOD  = 50_000_000,
    parameter int RD_PERIOD  = 100_000_000,
    parameter int CNT_W      = 27,
    parameter int STREAM_LEN = 64
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              fifo_rd_en,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt,
    output logic [1:0]        state
);

    localparam int N_MAX = (DEPTH > STREAM_LEN) ? DEPTH : STREAM_LEN;
    localparam int N_W   = $clog2(N_MAX) + 2;

    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PERIOD - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_PERIOD - 1);
    localparam logic [N_W-1:0]   DEPTH_N = N_W'(DEPTH);
    localparam logic [N_W-1:0]   LEN_N   = N_W'(STREAM_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FILL   = 2'b01,
        S_DRAIN  = 2'b10,
        S_STREAM = 2'b11
    } state_t;

    state_t cur_state, nxt_state;

    logic [CNT_W-1:0]  wr_cnt, rd_cnt;
    logic [DATA_W-1:0] wr_seq, rd_seq;
    logic [N_W-1:0]    n_wr, n_rd;
    logic              cmp_pend;
    logic              wr_tick, rd_tick;
    logic [N_W-1:0]    rd_target;
    logic              rd_room;

    assign busy         = (cur_state != S_IDLE);
    assign state        = cur_state;
    assign fifo_wr_data = wr_seq;

    assign wr_tick = busy && (wr_cnt == WR_LAST);
    assign rd_tick = busy && (rd_cnt == RD_LAST);

    // Reads in flight (n_rd plus one awaiting compare) must not exceed the target.
    assign rd_target = (cur_state == S_DRAIN) ? n_wr : LEN_N;
    assign rd_room   = ((n_rd + N_W'(cmp_pend)) < rd_target);

    always_ff @(posedge CLOCK_50) begin
        if (reset) cur_state <= S_IDLE;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:   if (start) nxt_state = mode ? S_STREAM : S_FILL;
            S_FILL:   if ((n_wr == DEPTH_N) || (fifo_full && (n_wr != '0))) nxt_state = S_DRAIN;
            S_DRAIN:  if (n_rd == n_wr) nxt_state = S_IDLE;
            S_STREAM: if (n_rd == LEN_N) nxt_state = S_IDLE;
            default:  nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        case (cur_state)
            S_FILL:   fifo_wr_en = wr_tick && !fifo_full && (n_wr < DEPTH_N);
            S_DRAIN:  fifo_rd_en = rd_tick && !fifo_empty && rd_room;
            S_STREAM: begin
                fifo_wr_en = wr_tick && !fifo_full && (n_wr < LEN_N);
                fifo_rd_en = rd_tick && !fifo_empty && rd_room;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            wr_seq   <= '0;
            rd_seq   <= '0;
            n_wr     <= '0;
            n_rd     <= '0;
            cmp_pend <= 1'b0;
            err_cnt  <= 8'd0;
            done     <= 1'b0;
        end else if (cur_state == S_IDLE) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            cmp_pend <= 1'b0;
            if (start) begin
                wr_seq  <= '0;
                rd_seq  <= '0;
                n_wr    <= '0;
                n_rd    <= '0;
                err_cnt <= 8'd0;
                done    <= 1'b0;
            end
        end else begin
            wr_cnt   <= wr_tick ? '0 : wr_cnt + 1'b1;
            rd_cnt   <= rd_tick ? '0 : rd_cnt + 1'b1;
            cmp_pend <= fifo_rd_en;
            if (fifo_wr_en) begin
                wr_seq <= wr_seq + 1'b1;
                n_wr   <= n_wr + 1'b1;
            end
            // Read data returned for the previous cycle's strobe.
            if (cmp_pend) begin
                if ((fifo_rd_data != rd_seq) && (err_cnt != 8'hFF))
                    err_cnt <= err_cnt + 8'd1;
                rd_seq <= rd_seq + 1'b1;
                n_rd   <= n_rd + 1'b1;
            end
            if (nxt_state == S_IDLE) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_test_sequencer.sv
// tb/tb_fifo_test_sequencer.sv - randomized FIFO-model bench for fifo_test_sequencer
module tb_fifo_test_sequencer;

    localparam int WRP   = 2;
    localparam int LIMIT = 5000;

    logic        CLOCK_50;
    logic        reset;
    logic        start_v   [2];
    logic        mode_v    [2];
    logic        f_full    [2];
    logic        f_empty   [2];
    logic [15:0] rdd       [2];
    logic        wr_en_v   [2];
    logic [15:0] wr_data_v [2];
    logic        rd_en_v   [2];
    logic        busy_v    [2];
    logic        done_v    [2];
    logic [7:0]  err_v     [2];
    logic [1:0]  state_v   [2];

    int          cap [2], cnt [2], wp [2], rp [2];
    logic [15:0] mem [2][16];
    logic        flush [2];
    int          cmode [2], cidx [2];
    logic        wr_op [2], rd_op [2];
    logic [15:0] wr_d [2], rd_w [2];
    int          nwr [2], nrd [2], xerr [2], k [2], last_rd_k [2];
    bit          saw_full [2];

    int n_cmp = 0;
    int n_bad = 0;

    fifo_test_sequencer #(.DATA_W(16), .DEPTH(16), .WR_PERIOD(2), .RD_PERIOD(3),
                          .CNT_W(4), .STREAM_LEN(300)) dut_a (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start_v[0]), .mode(mode_v[0]),
        .fifo_full(f_full[0]), .fifo_empty(f_empty[0]), .fifo_rd_data(rdd[0]),
        .fifo_wr_en(wr_en_v[0]), .fifo_wr_data(wr_data_v[0]), .fifo_rd_en(rd_en_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .err_cnt(err_v[0]), .state(state_v[0]));

    fifo_test_sequencer #(.DATA_W(16), .DEPTH(16), .WR_PERIOD(2), .RD_PERIOD(5),
                          .CNT_W(4), .STREAM_LEN(64)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start_v[1]), .mode(mode_v[1]),
        .fifo_full(f_full[1]), .fifo_empty(f_empty[1]), .fifo_rd_data(rdd[1]),
        .fifo_wr_en(wr_en_v[1]), .fifo_wr_data(wr_data_v[1]), .fifo_rd_en(rd_en_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .err_cnt(err_v[1]), .state(state_v[1]));

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int rd_period(input int i);
        return (i == 0) ? 3 : 5;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            f_full[i]  = (cnt[i] >= cap[i]);
            f_empty[i] = (cnt[i] == 0);
        end
    end

    // Observe strobes mid-cycle and score them against the sequence rules.
    always @(negedge CLOCK_50) begin
        for (int i = 0; i < 2; i++) begin
            logic [15:0] w;
            wr_op[i] = wr_en_v[i];
            rd_op[i] = rd_en_v[i];
            wr_d[i]  = wr_data_v[i];
            if (busy_v[i]) begin
                if (f_full[i]) saw_full[i] = 1'b1;
                if (wr_en_v[i]) begin
                    check("wr_data", int'(wr_data_v[i]), nwr[i] % 65536);
                    check("wr_while_full", int'(f_full[i]), 0);
                    check("wr_tick_phase", k[i] % WRP, WRP - 1);
                    nwr[i]++;
                end
                if (rd_en_v[i]) begin
                    check("rd_while_empty", int'(f_empty[i]), 0);
                    check("rd_tick_phase", k[i] % rd_period(i), rd_period(i) - 1);
                    w = mem[i][rp[i]];
                    case (cmode[i])
                        1: if (nrd[i] == cidx[i]) w = w ^ 16'd1;
                        2: w = 16'hFFFF;
                        3: if ($urandom_range(3, 0) == 0) w = w ^ (16'd1 << $urandom_range(15, 0));
                        default: ;
                    endcase
                    rd_w[i] = w;
                    if ((w != 16'(nrd[i])) && (xerr[i] < 255)) xerr[i]++;
                    nrd[i]++;
                    last_rd_k[i] = k[i];
                end
                k[i]++;
            end
        end
    end

    always @(posedge CLOCK_50) begin
        for (int i = 0; i < 2; i++) begin
            if (flush[i]) begin
                cnt[i] <= 0;
                wp[i]  <= 0;
                rp[i]  <= 0;
            end else begin
                if (wr_op[i]) begin
                    mem[i][wp[i]] <= wr_d[i];
                    wp[i] <= (wp[i] + 1) % 16;
                end
                if (rd_op[i]) begin
                    rdd[i] <= rd_w[i];
                    rp[i]  <= (rp[i] + 1) % 16;
                end
                cnt[i] <= cnt[i] + int'(wr_op[i]) - int'(rd_op[i]);
            end
        end
    end

    task automatic setup(input int i, input int cp, input int cm, input int ci);
        cap[i] = cp; cmode[i] = cm; cidx[i] = ci;
        flush[i] = 1'b1;
        @(posedge CLOCK_50); #1;
        flush[i] = 1'b0;
        nwr[i] = 0; nrd[i] = 0; xerr[i] = 0; k[i] = 0; last_rd_k[i] = -1; saw_full[i] = 1'b0;
        repeat ($urandom_range(3, 0)) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_start(input int i, input bit m);
        start_v[i] = 1'b1;
        mode_v[i]  = m;
        @(posedge CLOCK_50); #1;
        start_v[i] = 1'b0;
        mode_v[i]  = 1'($urandom_range(1, 0));
        check("done_cleared", int'(done_v[i]), 0);
        check("run_state", int'(state_v[i]), m ? 3 : 1);
    endtask

    task automatic run(input int i, input bit m, input int cp, input int cm, input int ci,
                       input int exp_n, input int rep);
        int cyc;
        setup(i, cp, cm, ci);
        pulse_start(i, m);
        cyc = 0;
        while (busy_v[i] && cyc < LIMIT) begin
            start_v[i] = (rep != 0) && (cyc == rep);
            if (start_v[i]) mode_v[i] = !m;
            @(posedge CLOCK_50); #1;
            cyc++;
            start_v[i] = 1'b0;
            if ((rep != 0) && (cyc == rep + 1)) check("start_ignored", int'(state_v[i]), m ? 3 : 1);
        end
        check("run_finished", int'(busy_v[i]), 0);
        check("end_done", int'(done_v[i]), 1);
        check("end_state", int'(state_v[i]), 0);
        check("end_err_cnt", int'(err_v[i]), xerr[i]);
        check("n_writes", nwr[i], exp_n);
        check("n_reads", nrd[i], exp_n);
        check("idle_after_last_cmp", k[i], last_rd_k[i] + 3);
    endtask

    initial begin
        int cyc;
        int cp;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; mode_v[i] = 1'b0; rdd[i] = 16'd0;
            cap[i] = 16; cnt[i] = 0; wp[i] = 0; rp[i] = 0; flush[i] = 1'b0;
            cmode[i] = 0; cidx[i] = 0; wr_op[i] = 1'b0; rd_op[i] = 1'b0;
            wr_d[i] = 16'd0; rd_w[i] = 16'd0;
            nwr[i] = 0; nrd[i] = 0; xerr[i] = 0; k[i] = 0; last_rd_k[i] = -1; saw_full[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_state", int'(state_v[i]), 0);
            check("rst_busy", int'(busy_v[i]), 0);
            check("rst_done", int'(done_v[i]), 0);
            check("rst_err", int'(err_v[i]), 0);
            check("rst_wr_en", int'(wr_en_v[i]), 0);
            check("rst_rd_en", int'(rd_en_v[i]), 0);
        end
        reset = 1'b0;

        run(0, 1'b0, 16, 0, 0, 16, 0);
        run(0, 1'b0, 16, 1, 4, 16, 0);
        check("bit0_flip_err", int'(err_v[0]), 1);
        run(1, 1'b1, 16, 0, 0, 64, 0);
        check("stream_hit_full", int'(saw_full[1]), 1);

        setup(0, 16, 1, 0);
        pulse_start(0, 1'b0);
        cyc = 0;
        while (!(state_v[0] == 2'b10 && nrd[0] >= 3) && cyc < LIMIT) begin
            @(posedge CLOCK_50); #1;
            cyc++;
        end
        check("reached_drain", int'(state_v[0]), 2);
        check("pre_reset_err", int'(err_v[0]), xerr[0]);
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        check("abort_state", int'(state_v[0]), 0);
        check("abort_rd_en", int'(rd_en_v[0]), 0);
        check("abort_wr_en", int'(wr_en_v[0]), 0);
        check("abort_err", int'(err_v[0]), 0);
        check("abort_busy", int'(busy_v[0]), 0);
        reset = 1'b0;
        run(0, 1'b0, 16, 0, 0, 16, 0);

        for (int n = 0; n < 6; n++) begin
            cp = $urandom_range(16, 1);
            run(0, 1'b0, cp, 3, 0, cp, 0);
        end
        for (int n = 0; n < 3; n++) begin
            run(1, 1'b1, $urandom_range(16, 1), 3, 0, 64, 0);
        end

        run(0, 1'b1, 16, 2, 0, 300, 50);
        check("err_saturated", int'(err_v[0]), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_test_sequencer.md
Name: fifo_test_sequencer

Overview:
Single-clock traffic controller that exercises the board-level async FIFO from CLOCK_50 using periodic write/read tick enables instead of derived clocks. Generates an incrementing write pattern, issues FIFO reads, checks returned data against the expected sequence and counts mismatches. Status outputs are sized to drive LEDR/LEDG directly. Runs in two modes: fill-then-drain, and continuous stream.

Parameters:
DATA_W, 16, FIFO data width
DEPTH, 16, FIFO capacity in words; write limit for fill-then-drain mode
WR_PERIOD, 50_000_000, CLOCK_50 cycles between write ticks (>=1)
RD_PERIOD, 100_000_000, CLOCK_50 cycles between read ticks (>=1)
CNT_W, 27, prescaler counter width; must hold max(WR_PERIOD, RD_PERIOD)-1
STREAM_LEN, 64, words written and read in stream mode

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  begin a run; sampled only in IDLE
mode  in  1  0 = fill-then-drain, 1 = stream; sampled with start
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_rd_data  in  DATA_W  FIFO read data, valid the cycle after fifo_rd_en
fifo_wr_en  out  1  one-cycle write strobe
fifo_wr_data  out  DATA_W  write pattern, valid with fifo_wr_en
fifo_rd_en  out  1  one-cycle read strobe
busy  out  1  high in any state other than IDLE
done  out  1  sticky; set on run completion, cleared by start or reset
err_cnt  out  8  mismatch count, saturates at 255
state  out  2  IDLE=00, FILL=01, DRAIN=10, STREAM=11

Behaviour:
- Reset, effective at the next edge: state IDLE, all outputs 0, internal counters 0. Reset asserted mid-run aborts the run at that edge; wr_en/rd_en are low from that edge on. The FIFO is not reset by this block.
- Prescalers: wr_cnt and rd_cnt are cleared on leaving IDLE and count only while busy. wr_tick is high for one cycle when wr_cnt == WR_PERIOD-1; wr_cnt then wraps to 0. rd_tick/rd_cnt work the same way.
- IDLE: when start=1, clear err_cnt, done, wr_seq, rd_seq, n_wr, n_rd. Go to FILL if mode=0, otherwise STREAM. start is ignored in every other state.
- Write rule (FILL, STREAM), on wr_tick:
  - If !fifo_full: fifo_wr_en=1 for one cycle, fifo_wr_data=wr_seq, then wr_seq++ and n_wr++.
  - If fifo_full: the tick is dropped; wr_seq does not advance.
- Read rule (DRAIN, STREAM), on rd_tick:
  - If !fifo_empty: fifo_rd_en=1 for one cycle.
  - Next cycle: compare fifo_rd_data with rd_seq. On mismatch, err_cnt++ (saturating). Then rd_seq++ and n_rd++.
  - If fifo_empty: the tick is dropped.
- FILL -> DRAIN: when n_wr == DEPTH, or when fifo_full=1 with n_wr>0 (FIFO smaller than DEPTH). The drain target is n_wr.
- DRAIN -> IDLE: one cycle after the final compare (n_rd == drain target); set done.
- STREAM:
  - Writes and reads run independently. A write tick and a read tick in the same cycle both act.
  - Writes stop after STREAM_LEN issued.
  - -> IDLE with done set once n_rd == STREAM_LEN.
- Never assert fifo_wr_en while fifo_full=1 or fifo_rd_en while fifo_empty=1, evaluated in the strobe cycle.
- wr_seq and rd_seq are DATA_W-bit and wrap modulo 2^DATA_W. n_wr and n_rd are wide enough for max(DEPTH, STREAM_LEN).
- A rd_tick coinciding with the pending-compare cycle is legal. Compare and new strobe overlap, which supports one read per cycle when RD_PERIOD=1.

Test Plan:
1. Assert reset 2 cycles -> state=00, busy=0, done=0, err_cnt=0, fifo_wr_en=fifo_rd_en=0.
2. WR_PERIOD=2, RD_PERIOD=3, 16-deep FIFO model; start with mode=0 -> 16 writes of data 0..15 spaced 2 cycles; then 16 reads spaced 3 cycles; err_cnt=0; done=1; state returns 00.
3. Same as 2, but the model flips bit 0 of the 5th read word -> err_cnt=1, done=1.
4. Stream mode, WR_PERIOD=2, RD_PERIOD=5, STREAM_LEN=64 -> FIFO reaches full; fifo_wr_en is never high while full; 64 writes/reads of data 0..63; err_cnt=0.
5. Reset asserted mid-DRAIN -> next edge state=00, rd_en=0, err_cnt=0. A subsequent start runs a full pass with done=1.
6. Stream, STREAM_LEN=300, model returns constant 0xFFFF; start pulsed again mid-run -> start is ignored; err_cnt saturates at 255.
